// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter driving a gated 2:1 output mux shared by requesters A and B.
// Grants are bounded to MAX_HOLD cycles under contention, with one idle cycle on every hand-over.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             CLK,
  input  logic             RSTbar,
  input  logic             REQA,
  input  logic             REQB,
  input  logic [WIDTH-1:0] DA,
  input  logic [WIDTH-1:0] DB,
  output logic             GNTA,
  output logic             GNTB,
  output logic             SEL,
  output logic             Gbar,
  output logic [WIDTH-1:0] Y
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            last_reg;   // 0 = A served last, 1 = B served last
  logic            gnta_reg;
  logic            gntb_reg;
  logic            sel_reg;
  logic            gbar_reg;
  logic            hold_done;

  assign hold_done = (cnt_reg == CW'(MAX_HOLD - 1));

  always_ff @(posedge CLK) begin
    if (!RSTbar) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= 1'b1;
      gnta_reg  <= 1'b0;
      gntb_reg  <= 1'b0;
      sel_reg   <= 1'b0;
      gbar_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          // On a tie the side that was not served last wins.
          if (REQA && (!REQB || last_reg)) begin
            state_reg <= GRANT_A;
            gnta_reg  <= 1'b1;
            sel_reg   <= 1'b0;
            gbar_reg  <= 1'b0;
            cnt_reg   <= '0;
          end else if (REQB) begin
            state_reg <= GRANT_B;
            gntb_reg  <= 1'b1;
            sel_reg   <= 1'b1;
            gbar_reg  <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        GRANT_A: begin
          if (!REQA || (hold_done && REQB)) begin
            state_reg <= IDLE;
            gnta_reg  <= 1'b0;
            gbar_reg  <= 1'b1;
            last_reg  <= 1'b0;
            cnt_reg   <= '0;
          end else if (hold_done) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        GRANT_B: begin
          if (!REQB || (hold_done && REQA)) begin
            state_reg <= IDLE;
            gntb_reg  <= 1'b0;
            gbar_reg  <= 1'b1;
            last_reg  <= 1'b1;
            cnt_reg   <= '0;
          end else if (hold_done) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnta_reg  <= 1'b0;
          gntb_reg  <= 1'b0;
          gbar_reg  <= 1'b1;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign GNTA = gnta_reg;
  assign GNTB = gntb_reg;
  assign SEL  = sel_reg;
  assign Gbar = gbar_reg;

  // Gated mux: output forced low whenever the enable is inactive.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
      assign Y[gi] = ~gbar_reg & (sel_reg ? DB[gi] : DA[gi]);
    end
  endgenerate

endmodule
